// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: default sizing and configuration check shared by the pipelined adder
package pipe_add_pkg;
    localparam int PA_WIDTH  = 16;
    localparam int PA_STAGES = 4;

    function automatic bit pa_cfg_ok(input int width, input int stages);
        return width >= 1 && stages >= 1 && (width % stages) == 0;
    endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational CHUNK-bit ripple chain of full-adder cells
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    assign cout = c[CHUNK];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple adder split into STAGES registered slices with full-pipeline stall
module pipelined_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = PA_WIDTH,
    parameter int STAGES = PA_STAGES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    if (!pa_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic                         adv;
    logic [STAGES-1:0]            v_q, c_q, v_i, c_i, co;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q, a_i, b_i, sum_i, sum_d;
    logic [STAGES-1:0][CHUNK-1:0] ss;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign v_i[s]   = in_valid;
            assign c_i[s]   = cin;
            assign a_i[s]   = a;
            assign b_i[s]   = b;
            assign sum_i[s] = '0;
        end else begin : g_body
            assign v_i[s]   = v_q[s-1];
            assign c_i[s]   = c_q[s-1];
            assign a_i[s]   = a_q[s-1];
            assign b_i[s]   = b_q[s-1];
            assign sum_i[s] = sum_q[s-1];
        end
        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (a_i[s][s*CHUNK +: CHUNK]),
            .b    (b_i[s][s*CHUNK +: CHUNK]),
            .cin  (c_i[s]),
            .sum  (ss[s]),
            .cout (co[s])
        );
        // slice s of the incoming partial sum is still zero, so OR merges the new chunk in
        assign sum_d[s] = sum_i[s] | (WIDTH'(ss[s]) << (s * CHUNK));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (adv) begin
            v_q   <= v_i;
            c_q   <= co;
            a_q   <= a_i;
            b_q   <= b_i;
            sum_q <= sum_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &
                       (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule
